// File: rtl/correlation_loader.sv
// correlation_loader: gathers a 17-word serial frame (16 candidates + 1 target) and presents it in parallel.
// A two-state LOAD/PRESENT handshake decides when the frame is shown and when the next load starts.
module correlation_loader #(
    parameter int WIDTH        = 32,
    parameter int TARGET_FIRST = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Flush,
    input  logic             Frame_Ack,
    output logic [WIDTH-1:0] Num_1,
    output logic [WIDTH-1:0] Num_2,
    output logic [WIDTH-1:0] Num_3,
    output logic [WIDTH-1:0] Num_4,
    output logic [WIDTH-1:0] Num_5,
    output logic [WIDTH-1:0] Num_6,
    output logic [WIDTH-1:0] Num_7,
    output logic [WIDTH-1:0] Num_8,
    output logic [WIDTH-1:0] Num_9,
    output logic [WIDTH-1:0] Num_10,
    output logic [WIDTH-1:0] Num_11,
    output logic [WIDTH-1:0] Num_12,
    output logic [WIDTH-1:0] Num_13,
    output logic [WIDTH-1:0] Num_14,
    output logic [WIDTH-1:0] Num_15,
    output logic [WIDTH-1:0] Num_16,
    output logic [WIDTH-1:0] Target_Num,
    output logic             Frame_Valid,
    output logic [4:0]       Word_Idx,
    output logic [7:0]       Frame_Cnt
);
    localparam logic [0:0] LOAD     = 1'b0;
    localparam logic [0:0] PRESENT  = 1'b1;
    localparam logic [4:0] TGT_IDX  = (TARGET_FIRST != 0) ? 5'd0 : 5'd16;
    localparam logic [4:0] NUM_BASE = (TARGET_FIRST != 0) ? 5'd1 : 5'd0;

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [0:0]       state;
    logic [4:0]       idx;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] num [16];
    logic [WIDTH-1:0] target;
    logic             accept;

    // Assertion is immediate; release passes through two flops before the core leaves reset.
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n  = rst_sync[1];
    assign accept = (state == LOAD) && In_Valid && !Flush;

    always_ff @(posedge Clock or negedge rst_n)
        if (!rst_n) begin
            state <= LOAD;
            idx   <= '0;
            cnt   <= '0;
        end else if (Flush || (state == PRESENT && Frame_Ack)) begin
            state <= LOAD;
            idx   <= '0;
        end else if (accept) begin
            idx <= idx + 5'd1;
            if (idx == 5'd16) begin
                state <= PRESENT;
                cnt   <= cnt + 8'd1;
            end
        end

    always_ff @(posedge Clock or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) num[i] <= '0;
            target <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++)
                if (idx == NUM_BASE + 5'(i)) num[i] <= In_Data;
            if (idx == TGT_IDX) target <= In_Data;
        end

    assign In_Ready    = (state == LOAD);
    assign Frame_Valid = (state == PRESENT);
    assign Word_Idx    = idx;
    assign Frame_Cnt   = cnt;
    assign Target_Num  = target;
    assign Num_1  = num[0];
    assign Num_2  = num[1];
    assign Num_3  = num[2];
    assign Num_4  = num[3];
    assign Num_5  = num[4];
    assign Num_6  = num[5];
    assign Num_7  = num[6];
    assign Num_8  = num[7];
    assign Num_9  = num[8];
    assign Num_10 = num[9];
    assign Num_11 = num[10];
    assign Num_12 = num[11];
    assign Num_13 = num[12];
    assign Num_14 = num[13];
    assign Num_15 = num[14];
    assign Num_16 = num[15];
endmodule

// File: doc/correlation_loader.md
CORRELATION_LOADER -- requirements
Module: correlation_loader

Interface
REQ-001 Parameter WIDTH, default 32: width of every data word.
REQ-002 Parameter TARGET_FIRST, default 0: 0 = target word is last in the frame, 1 = target word is first.
REQ-003 The block SHALL use one clock, Clock; reset is asynchronous and active-low, port Reset.
REQ-004 Clock  input  1  rising-edge system clock.
REQ-005 Reset  input  1  asynchronous active-low reset.
REQ-006 In_Data  input  WIDTH  serial word stream.
REQ-007 In_Valid  input  1  In_Data valid this cycle.
REQ-008 In_Ready  output  1  block accepts a word this cycle.
REQ-009 Flush  input  1  synchronous abort of the current frame.
REQ-010 Frame_Ack  input  1  consumer has taken the presented frame.
REQ-011 Num_1 .. Num_16  output  WIDTH each  parallel candidate words.
REQ-012 Target_Num  output  WIDTH  parallel target word.
REQ-013 Frame_Valid  output  1  all 17 outputs form a complete, stable frame.
REQ-014 Word_Idx  output  5  number of words accepted in the current frame, 0..17.
REQ-015 Frame_Cnt  output  8  completed frames, modulo 256.

Function
REQ-016 The FSM SHALL have exactly two states: LOAD (In_Ready=1, Frame_Valid=0) and PRESENT (In_Ready=0, Frame_Valid=1); In_Ready and Frame_Valid are decoded from registered state only.
REQ-017 A word SHALL be accepted on a rising edge where In_Valid=1, In_Ready=1 and Flush=0; Word_Idx then increments by 1.
REQ-018 With TARGET_FIRST=0, accepted word k (k=0..15) SHALL load Num_(k+1) and word 16 SHALL load Target_Num; with TARGET_FIRST=1, word 0 SHALL load Target_Num and word k (k=1..16) SHALL load Num_k.
REQ-019 Acceptance of word 16 SHALL move LOAD->PRESENT on the same edge: Frame_Valid=1, In_Ready=0 and Word_Idx=17 in the following cycle; Frame_Cnt increments by 1 on that edge, wrapping 255->0.
REQ-020 In PRESENT, Num_1..Num_16 and Target_Num SHALL hold constant, and In_Valid SHALL be ignored.
REQ-021 Frame_Ack=1 sampled in PRESENT SHALL move PRESENT->LOAD and clear Word_Idx to 0; Frame_Valid=0 and In_Ready=1 in the next cycle; the data outputs keep their values.
REQ-022 Frame_Ack sampled in LOAD SHALL have no effect.
REQ-023 Flush=1 SHALL, in either state, force LOAD and clear Word_Idx to 0 on that edge; data registers and Frame_Cnt are unchanged.
REQ-024 Flush together with In_Valid in LOAD: Flush SHALL win and the word is discarded.
REQ-025 Flush together with Frame_Ack in PRESENT: the result SHALL be the same as Frame_Ack alone.
REQ-026 In LOAD, a word whose In_Valid gap spans any number of idle cycles SHALL be accepted without loss; the block imposes no timeout.
REQ-027 Minimum frame period SHALL be 18 cycles: 17 load cycles plus 1 PRESENT cycle when Frame_Ack is held high.

Reset
REQ-028 Reset low SHALL immediately, without a clock edge, force LOAD, Word_Idx=0, Frame_Cnt=0, Frame_Valid=0, In_Ready=1, and all Num_1..Num_16 and Target_Num to 0.
REQ-029 Reset asserted mid-frame or during PRESENT SHALL discard the partial frame; after deassertion the next accepted word is word 0.
REQ-030 Reset deassertion SHALL be synchronised internally so the first acceptance occurs no earlier than the second rising edge after release.

Verification
REQ-031 Back-to-back load, TARGET_FIRST=0, words 1..17 with In_Valid held high -> after the 17th edge Frame_Valid=1, Num_1=1 .. Num_16=16, Target_Num=17, Frame_Cnt=1, In_Ready=0.
REQ-032 Same stream with In_Valid toggling every other cycle -> identical outputs; Word_Idx steps 0..17 only on accepted cycles.
REQ-033 In PRESENT, drive In_Valid=1, In_Data=32'hDEADBEEF for 5 cycles, then Frame_Ack=1 for 1 cycle -> outputs unchanged throughout; next cycle Frame_Valid=0, In_Ready=1, Word_Idx=0.
REQ-034 Accept 9 words, then Flush=1 with In_Valid=1 -> Word_Idx=0, Frame_Cnt unchanged; a fresh 17-word load then completes normally.
REQ-035 Pull Reset low asynchronously, between edges, after 12 words -> Frame_Valid=0, all data outputs 0 before the next edge; after release a full frame loads correctly.
REQ-036 Run 257 frames with Frame_Ack tied high -> Frame_Cnt=1; each frame is presented for exactly 1 cycle.
